// File: rtl/round_arbiter.sv
// Round-robin arbiter that shares one 2-stage rounding unit among NREQ requesters,
// tracking each operand with a tag pipeline kept in step with the rounding unit.
module round_arbiter #(
  parameter int NREQ     = 4,
  parameter int INWIDTH  = 33,
  parameter int OUTWIDTH = 16,
  parameter int IDW      = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NREQ-1:0]          REQ_VALID,
  input  logic [NREQ*INWIDTH-1:0]  REQ_DATA,
  output logic [NREQ-1:0]          REQ_READY,
  output logic                     RND_EN,
  output logic [INWIDTH-1:0]       RND_DIN,
  input  logic [OUTWIDTH-1:0]      RND_DOUT,
  input  logic                     RND_SATUR,
  output logic                     RES_VALID,
  input  logic                     RES_READY,
  output logic [IDW-1:0]           RES_ID,
  output logic [OUTWIDTH-1:0]      RES_DATA,
  output logic                     RES_SATUR,
  input  logic                     CLR_CNT,
  output logic [15:0]              SAT_CNT
);

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  tag_t           tag_s1;
  tag_t           tag_s2;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_next;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] lo_idx;
  logic           hi_found;
  logic           any_valid;
  logic           stall;
  logic           transfer;
  logic           sat_inc;
  logic [15:0]    sat_cnt_q;

  assign stall     = tag_s2.valid & ~RES_READY;
  assign RND_EN    = ~stall;
  assign any_valid = |REQ_VALID;
  assign transfer  = any_valid & ~stall;

  // Two-window search: lowest valid index at or above ptr wins, otherwise the
  // lowest valid index overall (the wrap-around half of the rotation).
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (REQ_VALID[i]) begin
        lo_idx = IDW'(i);
        if (IDW'(i) >= ptr) begin
          hi_idx   = IDW'(i);
          hi_found = 1'b1;
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    REQ_READY = '0;
    RND_DIN   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_idx) begin
        REQ_READY[i] = transfer;
        if (any_valid) begin
          RND_DIN = REQ_DATA[i*INWIDTH +: INWIDTH];
        end
      end
    end
  end

  assign ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // Tags advance only with RND_EN so they stay aligned with the rounding stages.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tag_s1 <= '0;
      tag_s2 <= '0;
      ptr    <= '0;
    end else if (RND_EN) begin
      tag_s2 <= tag_s1;
      if (transfer) begin
        tag_s1 <= tag_t'{valid: 1'b1, id: grant_idx};
        ptr    <= ptr_next;
      end else begin
        tag_s1 <= '0;
      end
    end
  end

  assign sat_inc = tag_s2.valid & RES_READY & RND_SATUR;

  // A clear coinciding with a counted result keeps that result.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sat_cnt_q <= '0;
    end else if (CLR_CNT) begin
      sat_cnt_q <= sat_inc ? 16'd1 : 16'd0;
    end else if (sat_inc && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign RES_VALID = tag_s2.valid;
  assign RES_ID    = tag_s2.id;
  assign RES_DATA  = RND_DOUT;
  assign RES_SATUR = RND_SATUR;
  assign SAT_CNT   = sat_cnt_q;

endmodule

// File: tb/tb_round_arbiter.sv
// Self-checking bench for round_arbiter with a behavioural 2-stage rounding unit
// (Q6.26 -> Q2.13, round half up, signed saturation).
module tb_round_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [131:0] req_data;
  logic [3:0]   req_ready;
  logic         rnd_en;
  logic [32:0]  rnd_din;
  logic [15:0]  rnd_dout;
  logic         rnd_satur;
  logic         res_valid;
  logic         res_ready;
  logic [1:0]   res_id;
  logic [15:0]  res_data;
  logic         res_satur;
  logic         clr_cnt;
  logic [15:0]  sat_cnt;

  int checks = 0;
  int errors = 0;

  round_arbiter #(.NREQ(4), .INWIDTH(33), .OUTWIDTH(16), .IDW(2)) dut (
    .CLK(clk), .RESET(reset),
    .REQ_VALID(req_valid), .REQ_DATA(req_data), .REQ_READY(req_ready),
    .RND_EN(rnd_en), .RND_DIN(rnd_din), .RND_DOUT(rnd_dout), .RND_SATUR(rnd_satur),
    .RES_VALID(res_valid), .RES_READY(res_ready), .RES_ID(res_id),
    .RES_DATA(res_data), .RES_SATUR(res_satur),
    .CLR_CNT(clr_cnt), .SAT_CNT(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rounding unit model: {satur, data} per stage.
  logic [16:0] m_s1;
  logic [16:0] m_s2;

  function automatic logic [16:0] round_q(input logic [32:0] v);
    logic signed [33:0] r;
    r = ($signed({v[32], v}) + 34'sd4096) >>> 13;
    if (r > 34'sd32767) return {1'b1, 16'h7FFF};
    if (r < -34'sd32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_s1 <= '0;
      m_s2 <= '0;
    end else if (rnd_en) begin
      m_s1 <= round_q(rnd_din);
      m_s2 <= m_s1;
    end
  end

  assign rnd_dout  = m_s2[15:0];
  assign rnd_satur = m_s2[16];

  // Expected rounded result per requester for the normal data set.
  logic [15:0] exp_data_of [4];

  typedef struct {
    logic [3:0] valid;
    logic       rdy;
    logic [3:0] exp_ready;
    logic       exp_en;
    logic       exp_rv;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs [25];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_data(input logic [32:0] d0);
    req_data = {33'h0300_0000, 33'h0400_0000, 33'h0200_0000, d0};
  endtask

  initial begin
    exp_data_of[0] = 16'h0800;
    exp_data_of[1] = 16'h1000;
    exp_data_of[2] = 16'h2000;
    exp_data_of[3] = 16'h1800;

    //          valid    rdy   ready    en    rv    id
    vecs[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, 2'd0};
    vecs[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0};
    vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2};
    vecs[3]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 1'b0, 2'd0};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd3};
    vecs[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd0};
    vecs[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd1};
    vecs[8]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd2};
    vecs[9]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd3};
    vecs[10] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0};
    vecs[11] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0};
    vecs[12] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0};
    vecs[13] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd0};
    vecs[14] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1};
    vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2};
    vecs[16] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0};
    vecs[17] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd0};
    vecs[18] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0};
    vecs[19] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd1};
    vecs[20] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0};
    vecs[21] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd3};
    vecs[22] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0};
    vecs[23] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1};
    vecs[24] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0};

    reset     = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    clr_cnt   = 1'b0;
    set_data(33'h0100_0000);
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset_res_valid", res_valid, 1'b0);
    check("reset_res_id", res_id, 2'd0);
    check("reset_sat_cnt", sat_cnt, 16'd0);
    check("reset_rnd_en", rnd_en, 1'b1);
    check("reset_req_ready", req_ready, 4'b0000);

    // Single operand, fairness, backpressure, sparse traffic.
    for (int i = 0; i < 25; i++) begin
      req_valid = vecs[i].valid;
      res_ready = vecs[i].rdy;
      #1;
      check($sformatf("row%0d_req_ready", i), req_ready, vecs[i].exp_ready);
      check($sformatf("row%0d_rnd_en", i), rnd_en, vecs[i].exp_en);
      check($sformatf("row%0d_res_valid", i), res_valid, vecs[i].exp_rv);
      check($sformatf("row%0d_res_id", i), res_id, vecs[i].exp_id);
      check($sformatf("row%0d_res_data", i), res_data,
            vecs[i].exp_rv ? exp_data_of[vecs[i].exp_id] : 16'h0000);
      check($sformatf("row%0d_res_satur", i), res_satur, 1'b0);
      tick();
    end

    // Saturation counting with a clear on the fourth counted result.
    set_data(33'h0FFF_FFFF);
    req_valid = 4'b0001;
    #1;
    check("sat_cnt_before", sat_cnt, 16'd0);
    check("sat_first_grant", req_ready, 4'b0001);
    tick(); tick(); tick(); tick();
    req_valid = 4'b0000;
    #1;
    check("sat_res_data", res_data, 16'h7FFF);
    check("sat_res_satur", res_satur, 1'b1);
    check("sat_cnt_two", sat_cnt, 16'd2);
    tick();
    #1;
    check("sat_cnt_three", sat_cnt, 16'd3);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    #1;
    check("sat_cnt_clr_inc", sat_cnt, 16'd1);
    tick();
    #1;
    check("sat_drain_valid", res_valid, 1'b0);
    check("sat_cnt_hold", sat_cnt, 16'd1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    #1;
    check("sat_cnt_clr_only", sat_cnt, 16'd0);

    // Reset mid-flight, asserted during a stall.
    set_data(33'h0100_0000);
    req_valid = 4'b0011;
    #1;
    check("rst_pre_grant1", req_ready, 4'b0010);
    tick();
    #1;
    check("rst_pre_grant0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    #1;
    check("rst_inflight_valid", res_valid, 1'b1);
    check("rst_inflight_id", res_id, 2'd1);
    res_ready = 1'b0;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    res_ready = 1'b1;
    req_valid = 4'b0011;
    #1;
    check("rst_after_valid", res_valid, 1'b0);
    check("rst_after_data", res_data, 16'h0000);
    check("rst_after_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    #1;
    check("rst_after_valid2", res_valid, 1'b0);
    tick();
    #1;
    check("rst_new_valid", res_valid, 1'b1);
    check("rst_new_id", res_id, 2'd0);
    check("rst_new_data", res_data, 16'h0800);
    tick();
    #1;
    check("rst_new_drain", res_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_arbiter.md
ROUND_ARBITER -- requirements
Module: round_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one rounding unit.
REQ-002 Parameter INWIDTH, default 33, width of each requester's wide fixed-point operand.
REQ-003 Parameter OUTWIDTH, default 16, width of the rounded result returned by the rounding unit.
REQ-004 Parameter IDW, default 2, requester-ID width, equal to clog2(NREQ) with a minimum of 1.
REQ-005 CLK  in  1  single clock; all state updates on the rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 REQ_VALID  in  NREQ  per-requester operand valid.
REQ-008 REQ_DATA  in  NREQ*INWIDTH  operands, requester i at bits [i*INWIDTH +: INWIDTH].
REQ-009 REQ_READY  out  NREQ  per-requester accept; transfer occurs when REQ_VALID[i] & REQ_READY[i].
REQ-010 RND_EN  out  1  enable driven to the 2-stage rounding unit.
REQ-011 RND_DIN  out  INWIDTH  operand driven to the rounding unit.
REQ-012 RND_DOUT  in  OUTWIDTH  rounding unit result.
REQ-013 RND_SATUR  in  1  rounding unit saturation flag, aligned with RND_DOUT.
REQ-014 RES_VALID  out  1  result valid.
REQ-015 RES_READY  in  1  downstream accept.
REQ-016 RES_ID  out  IDW  requester that issued the current result.
REQ-017 RES_DATA  out  OUTWIDTH  equal to RND_DOUT.
REQ-018 RES_SATUR  out  1  equal to RND_SATUR.
REQ-019 CLR_CNT  in  1  synchronous clear of SAT_CNT.
REQ-020 SAT_CNT  out  16  count of accepted results with RES_SATUR=1.

Function
REQ-021 The rounding unit is a 2-tick pipeline. Both stages advance only on edges where RND_EN=1. A value presented on RND_DIN with RND_EN=1 at edge t appears on RND_DOUT after the second RND_EN=1 edge.
REQ-022 stall = RES_VALID & ~RES_READY.
REQ-023 RND_EN = ~stall, combinational.
REQ-024 The block keeps a 2-stage tag pipeline {valid, id} that advances exactly when RND_EN=1, so it stays aligned with the rounding unit stages.
REQ-025 RES_VALID = stage-2 tag valid, and RES_ID = stage-2 tag id.
REQ-026 Grant selection is round-robin and combinational from pointer PTR (IDW bits): the first i with REQ_VALID[i]=1, searching from PTR upward modulo NREQ.
REQ-027 REQ_READY[i] = (i == granted index) & any REQ_VALID & ~stall. At most one bit of REQ_READY is set in any cycle.
REQ-028 RND_DIN is driven from the granted requester's REQ_DATA slice when a grant exists, and is 0 otherwise.
REQ-029 When a transfer occurs, stage-1 tag loads {1, granted index} and PTR loads (granted index + 1) mod NREQ.
REQ-030 When RND_EN=1 and no transfer occurs, stage-1 tag loads {0, 0} (a bubble) and PTR holds.
REQ-031 During a stall, REQ_READY is all zero, both tag stages hold, PTR holds, and RES_ID, RES_DATA and RES_SATUR stay stable.
REQ-032 Throughput is one result per cycle with no bubbles while RES_READY=1 and at least one requester is valid. Per-requester latency is exactly 2 cycles from acceptance to RES_VALID when no stall occurs.
REQ-033 Results leave the block in acceptance order.
REQ-034 A requester that drops REQ_VALID without a transfer is not remembered; no pending state is kept.
REQ-035 SAT_CNT increments by 1 on each RES_VALID & RES_READY & RES_SATUR edge and saturates at 16'hFFFF.
REQ-036 If CLR_CNT and an increment occur on the same edge, SAT_CNT loads 1.
REQ-037 If CLR_CNT is asserted with no increment, SAT_CNT loads 0.

Reset
REQ-038 While RESET=1 at a rising edge: both tag stages load {0,0}, PTR loads 0, and SAT_CNT loads 0. In the cycle after the reset edge, RES_VALID=0.
REQ-039 RESET has priority over all other inputs, including CLR_CNT and an active stall.
REQ-040 RESET asserted mid-operation discards all in-flight tags, so their results are never presented. The rounding unit must be reset by the same RESET.
REQ-041 No output may present X after the first reset edge.

Verification
REQ-042 Single operand: requester 2 only, valid for one cycle with data 33'h0400_0000 (1.0 in Q6.26), RES_READY=1 -> RES_VALID two cycles later with RES_ID=2, RES_DATA=16'h2000 and RES_SATUR=0.
REQ-043 Fairness: all four requesters held valid with PTR=0 and RES_READY=1 -> accepts occur in order 0,1,2,3,0,1,…; RES_ID repeats that sequence from cycle 2 onward with no bubbles.
REQ-044 Backpressure: RES_READY=0 for 3 cycles while RES_VALID=1 -> RND_EN=0 and REQ_READY=0 for all 3 cycles with outputs held stable; after release, the remaining results arrive in order with none lost or duplicated.
REQ-045 Saturation count: three operands of 33'h0FFF_FFFF all accepted, followed by CLR_CNT on the same edge as a fourth saturating acceptance -> SAT_CNT reads 3, then 1.
REQ-046 Reset mid-flight: assert RESET one cycle after two acceptances -> RES_VALID=0 afterwards until new traffic arrives, PTR=0, and the next grant goes to the lowest valid index.
REQ-047 Sparse traffic: requester 1 and requester 3 valid on alternate cycles -> bubbles appear as RES_VALID=0 exactly in the idle cycles, 2 cycles delayed.
